// File: rtl/frame_loader_if.sv
// Byte-stream and frame-bus bundle between a row-byte producer and frame_loader.
// Latency: none, wiring only.
// Backpressure: the producer holds byte_valid/byte_in until byte_ready is seen at a clock edge.
//
// Signals:
//   byte_in[7:0]           row data, bit k = LED k of the row
//   byte_valid             byte_in is valid this cycle
//   byte_ready             loader accepts a byte this cycle
//   frame_start            resync pulse, next accepted byte is byte 0
//   frame_cube_flat[511:0] front buffer, byte i at [8i+7:8i], i = layer*8 + row
//   frame_done             one-cycle pulse when the front buffer updates
//   frame_err              one-cycle pulse when a partial frame is aborted
interface frame_loader_if;
  logic [7:0]   byte_in;
  logic         byte_valid;
  logic         byte_ready;
  logic         frame_start;
  logic [511:0] frame_cube_flat;
  logic         frame_done;
  logic         frame_err;

  // Producer side (feeds bytes, observes the frame bus).
  modport master (
    output byte_in, byte_valid, frame_start,
    input  byte_ready, frame_cube_flat, frame_done, frame_err
  );

  // Loader side.
  modport slave (
    input  byte_in, byte_valid, frame_start,
    output byte_ready, frame_cube_flat, frame_done, frame_err
  );
endinterface

// File: rtl/frame_loader.sv
// Assembles a 64-byte LED-cube frame in a back buffer and swaps it whole into the front buffer.
// Latency: front buffer and frame_done update one clock after the last byte is accepted.
// Backpressure: byte_ready drops for the single swap cycle only; otherwise every offered byte is taken.
//
// Ports:
//   clk   system clock
//   rst   asynchronous, active-high reset
//   bus   frame_loader_if.slave (byte stream in, frame bus and status pulses out)
// Parameters:
//   TIMEOUT  idle cycles allowed between accepted bytes of one frame (>= 2)
//   TW       timeout counter width, 2**TW > TIMEOUT
// Build option:
//   FRAME_LOADER_CHKSUM_EN  frames carry a 65th byte holding the XOR of bytes 0..63;
//                           a mismatch aborts the frame instead of swapping it.
module frame_loader #(
  parameter int TIMEOUT = 100000,
  parameter int TW      = 17
) (
  input  logic          clk,
  input  logic          rst,
  frame_loader_if.slave bus
);

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    LOAD = 2'd1,
    CHK  = 2'd2,
    SWAP = 2'd3
  } state_t;

  state_t        state;
  logic [511:0]  back;
  logic [5:0]    ptr;
  logic [TW-1:0] tcnt;
  logic          accept;
`ifdef FRAME_LOADER_CHKSUM_EN
  logic [7:0]    chk;
`endif

  assign accept = bus.byte_valid && bus.byte_ready;

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state               <= IDLE;
      back                <= '0;
      ptr                 <= '0;
      tcnt                <= '0;
      bus.byte_ready      <= 1'b0;
      bus.frame_cube_flat <= '0;
      bus.frame_done      <= 1'b0;
      bus.frame_err       <= 1'b0;
`ifdef FRAME_LOADER_CHKSUM_EN
      chk                 <= '0;
`endif
    end else begin
      bus.frame_done <= 1'b0;
      bus.frame_err  <= 1'b0;

      case (state)
        IDLE: begin
          tcnt           <= '0;
          ptr            <= '0;
          bus.byte_ready <= 1'b1;
          // A resync in IDLE has nothing to discard, so it is simply a normal byte 0.
          if (accept) begin
            back[7:0] <= bus.byte_in;
            ptr       <= 6'd1;
            state     <= LOAD;
`ifdef FRAME_LOADER_CHKSUM_EN
            chk       <= bus.byte_in;
`endif
          end
        end

        SWAP: begin
          // frame_start and any offered byte are ignored here; the swap always completes.
          bus.frame_cube_flat <= back;
          bus.frame_done      <= 1'b1;
          ptr                 <= '0;
          tcnt                <= '0;
          bus.byte_ready      <= 1'b1;
          state               <= IDLE;
        end

        default: begin  // LOAD, and CHK when the checksum byte is expected
          if (bus.frame_start) begin
            // Resync outranks the running pointer: a simultaneous byte restarts the frame.
            bus.frame_err <= 1'b1;
            tcnt          <= '0;
            if (accept) begin
              back[7:0] <= bus.byte_in;
              ptr       <= 6'd1;
              state     <= LOAD;
`ifdef FRAME_LOADER_CHKSUM_EN
              chk       <= bus.byte_in;
`endif
            end else begin
              ptr   <= '0;
              state <= IDLE;
            end
          end else if (accept) begin
            // An accepted byte beats a timeout expiring in the same cycle.
            tcnt <= '0;
            if (state == LOAD) begin
              back[{ptr, 3'b000} +: 8] <= bus.byte_in;
              ptr                      <= ptr + 6'd1;
`ifdef FRAME_LOADER_CHKSUM_EN
              chk                      <= chk ^ bus.byte_in;
              if (ptr == 6'd63) begin
                state <= CHK;
              end
`else
              if (ptr == 6'd63) begin
                state          <= SWAP;
                bus.byte_ready <= 1'b0;
              end
`endif
            end
`ifdef FRAME_LOADER_CHKSUM_EN
            else begin
              ptr <= '0;
              if (bus.byte_in == chk) begin
                state          <= SWAP;
                bus.byte_ready <= 1'b0;
              end else begin
                bus.frame_err <= 1'b1;
                state         <= IDLE;
              end
            end
`endif
          end else if (tcnt == TW'(TIMEOUT - 1)) begin
            // This idle cycle would bring the count to TIMEOUT: abort, front buffer untouched.
            bus.frame_err <= 1'b1;
            tcnt          <= '0;
            ptr           <= '0;
            state         <= IDLE;
          end else begin
            tcnt <= tcnt + TW'(1);
          end
        end
      endcase
    end
  end

endmodule

// File: tb/tb_frame_loader.sv
// Directed bench for frame_loader: full frames, timeout abort, resync, gapped frames, async reset.
// Latency checks assume the front buffer and frame_done follow the last byte by one clock.
// Inputs are driven 1 ns after the rising edge; outputs are read there too.
module tb_frame_loader;
  localparam int TO  = 20;
  localparam int TWB = 5;

  logic clk;
  logic rst;

  frame_loader_if bus();

  frame_loader #(
    .TIMEOUT(TO),
    .TW     (TWB)
  ) dut (
    .clk(clk),
    .rst(rst),
    .bus(bus)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  int n_checks = 0;
  int n_fail   = 0;
  int done_cnt = 0;
  int err_cnt  = 0;
  int ready_bad = 0;

  logic [7:0]   mdl [64];
  logic [511:0] all_ones;
  logic [511:0] saved;

  always @(negedge clk) begin
    if (bus.frame_done === 1'b1) done_cnt++;
    if (bus.frame_err  === 1'b1) err_cnt++;
  end

  task automatic check(input string tag, input logic [511:0] got, input logic [511:0] exp);
    n_checks++;
    if (got !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0h expected %0h", tag, got, exp);
    end
  endtask

  function automatic logic [511:0] packm();
    logic [511:0] r;
    r = '0;
    for (int i = 0; i < 64; i++) r[8*i +: 8] = mdl[i];
    return r;
  endfunction

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic send_byte(input logic [7:0] b);
    if (bus.byte_ready !== 1'b1) ready_bad++;
    bus.byte_in    = b;
    bus.byte_valid = 1'b1;
    tick();
    bus.byte_valid = 1'b0;
  endtask

  // Sends mdl[start..63] (plus the XOR checksum when that build option is on),
  // with up to max_gap idle cycles before each byte after the first.
  task automatic send_frame(input int start, input int max_gap);
    logic [7:0] x;
    x = 8'h00;
    for (int i = 0; i < 64; i++) x ^= mdl[i];
    for (int i = start; i < 64; i++) begin
      if (i > start && max_gap > 0) repeat ($urandom_range(0, max_gap)) tick();
      send_byte(mdl[i]);
    end
`ifdef FRAME_LOADER_CHKSUM_EN
    send_byte(x);
`endif
  endtask

  int d0, e0, err_at;
  logic [511:0] f;

  initial begin
    all_ones         = '1;
    rst              = 1'b1;
    bus.byte_in      = 8'h00;
    bus.byte_valid   = 1'b0;
    bus.frame_start  = 1'b0;
    tick();
    tick();
    check("rst_flat",  bus.frame_cube_flat, 512'd0);
    check("rst_ready", 512'(bus.byte_ready), 512'd0);
    check("rst_done",  512'(bus.frame_done), 512'd0);
    check("rst_err",   512'(bus.frame_err),  512'd0);
    rst = 1'b0;
    tick();
    check("ready_after_rst", 512'(bus.byte_ready), 512'd1);

    // Frame of byte i = i, valid held high.
    for (int i = 0; i < 64; i++) mdl[i] = 8'(i);
    ready_bad = 0;
    d0 = done_cnt;
    send_frame(0, 0);
    check("t1_ready_swap",   512'(bus.byte_ready), 512'd0);
    check("t1_flat_before",  bus.frame_cube_flat, 512'd0);
    tick();
    f = bus.frame_cube_flat;
    check("t1_byte0",  512'(f[7:0]),     512'h00);
    check("t1_byte1",  512'(f[15:8]),    512'h01);
    check("t1_byte63", 512'(f[511:504]), 512'h3F);
    check("t1_flat",   f, packm());
    check("t1_done",   512'(bus.frame_done), 512'd1);
    check("t1_ready_back", 512'(bus.byte_ready), 512'd1);
    tick();
    check("t1_done_once", 512'(done_cnt - d0), 512'd1);
    check("t1_ready_held", 512'(ready_bad), 512'd0);

    // All-ones frame, then a partial frame that times out.
    for (int i = 0; i < 64; i++) mdl[i] = 8'hFF;
    send_frame(0, 0);
    tick();
    check("t2_ones", bus.frame_cube_flat, all_ones);
    e0 = err_cnt;
    for (int i = 0; i < 30; i++) send_byte(8'h00);
    err_at = 0;
    for (int k = 1; k <= TO + 3; k++) begin
      tick();
      if (bus.frame_err === 1'b1 && err_at == 0) err_at = k;
    end
    check("t2_err_cycle", 512'(err_at), 512'(TO));
    check("t2_err_once",  512'(err_cnt - e0), 512'd1);
    check("t2_front_kept", bus.frame_cube_flat, all_ones);
    for (int i = 0; i < 64; i++) mdl[i] = 8'(i) ^ 8'h5A;
    send_frame(0, 0);
    tick();
    check("t2_next_frame", bus.frame_cube_flat, packm());

    // Resync with a byte after 10 bytes.
    tick();
    e0 = err_cnt;
    d0 = done_cnt;
    for (int i = 0; i < 10; i++) send_byte(8'h10 + 8'(i));
    bus.frame_start = 1'b1;
    send_byte(8'hAA);
    bus.frame_start = 1'b0;
    check("t3_err", 512'(bus.frame_err), 512'd1);
    mdl[0] = 8'hAA;
    for (int i = 1; i < 64; i++) mdl[i] = 8'(i * 3);
    send_frame(1, 0);
    tick();
    check("t3_byte0", 512'(bus.frame_cube_flat[7:0]), 512'hAA);
    check("t3_flat",  bus.frame_cube_flat, packm());
    check("t3_done",  512'(bus.frame_done), 512'd1);
    tick();
    check("t3_err_once",  512'(err_cnt - e0),  512'd1);
    check("t3_done_once", 512'(done_cnt - d0), 512'd1);

    // Three frames with random gaps shorter than the timeout.
    e0 = err_cnt;
    d0 = done_cnt;
    for (int fr = 0; fr < 3; fr++) begin
      for (int i = 0; i < 64; i++) mdl[i] = 8'($urandom_range(0, 255));
      send_frame(0, 6);
      tick();
      check("t4_frame", bus.frame_cube_flat, packm());
    end
    tick();
    check("t4_done_cnt", 512'(done_cnt - d0), 512'd3);
    check("t4_no_err",   512'(err_cnt - e0),  512'd0);

    // Asynchronous reset between edges after 40 bytes.
    for (int i = 0; i < 64; i++) mdl[i] = 8'(255 - i);
    for (int i = 0; i < 40; i++) send_byte(mdl[i]);
    #3;
    rst = 1'b1;
    #1;
    check("t5_flat_rst",  bus.frame_cube_flat, 512'd0);
    check("t5_ready_rst", 512'(bus.byte_ready), 512'd0);
    check("t5_done_rst",  512'(bus.frame_done), 512'd0);
    tick();
    tick();
    check("t5_ready_held_low", 512'(bus.byte_ready), 512'd0);
    rst = 1'b0;
    tick();
    check("t5_ready_after", 512'(bus.byte_ready), 512'd1);
    send_frame(0, 0);
    tick();
    check("t5_clean_frame", bus.frame_cube_flat, packm());

`ifdef FRAME_LOADER_CHKSUM_EN
    // Good checksum (XOR of 0..63 is 0x00), then a frame of i+1 with a wrong checksum.
    tick();
    for (int i = 0; i < 64; i++) mdl[i] = 8'(i);
    send_frame(0, 0);
    tick();
    check("t6_good_chk", bus.frame_cube_flat, packm());
    saved = packm();
    tick();
    d0 = done_cnt;
    e0 = err_cnt;
    for (int i = 0; i < 64; i++) send_byte(8'(i + 1));
    send_byte(8'h01);
    check("t6_bad_err", 512'(bus.frame_err), 512'd1);
    tick();
    tick();
    check("t6_front_kept", bus.frame_cube_flat, saved);
    check("t6_no_done",    512'(done_cnt - d0), 512'd0);
    check("t6_err_once",   512'(err_cnt - e0),  512'd1);
`endif

    $display("TB_RESULT checks=%0d failures=%0d", n_checks, n_fail);
    $finish;
  end
endmodule
